// File: rtl/multicore_done_aggregator.sv
// Completion monitor for an N-core cluster: latches each core's result on the falling edge
// of its ready strobe, sums the results and times the run. Optional macro: PER_CORE_CYCLES_EN.
module multicore_done_aggregator #(
    parameter int unsigned CORES    = 4,
    parameter int unsigned RESULT_W = 8,
    parameter int unsigned CYCLE_W  = 16,
    parameter int unsigned SUM_W    = 16,
    parameter int unsigned TIMEOUT  = 50000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [CORES-1:0]            ready_in,
    input  logic [CORES*RESULT_W-1:0]   result_in,
    output logic [CORES-1:0]            core_done,
    output logic [CORES*RESULT_W-1:0]   result_lat,
    output logic [SUM_W-1:0]            total,
    output logic [CYCLE_W-1:0]          cycle_count,
    output logic                        busy,
    output logic                        all_done,
    output logic                        timed_out,
    output logic                        done_pulse
`ifdef PER_CORE_CYCLES_EN
    ,
    output logic [CORES*CYCLE_W-1:0]    core_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t                      r_state;
    logic [CORES-1:0]            r_ready_q;
    logic [CORES-1:0]            r_core_done;
    logic [CORES*RESULT_W-1:0]   r_result_lat;
    logic [SUM_W-1:0]            r_total;
    logic [CYCLE_W-1:0]          r_cycle_count;
    logic                        r_busy;
    logic                        r_all_done;
    logic                        r_timed_out;
    logic                        r_done_pulse;
`ifdef PER_CORE_CYCLES_EN
    logic [CORES*CYCLE_W-1:0]    r_core_cycles;
`endif

    logic [CORES-1:0]            w_fall;
    logic [CORES-1:0]            w_new;
    logic [CORES-1:0]            w_done_next;
    logic                        w_all;
    logic                        w_to;
    logic [SUM_W-1:0]            w_add;

    // A core completes on the first falling edge of its strobe during a run.
    assign w_fall      = r_ready_q & ~ready_in;
    assign w_new       = w_fall & ~r_core_done;
    assign w_done_next = r_core_done | w_new;
    assign w_all       = &w_done_next;
    assign w_to        = (TIMEOUT != 0) && (32'(r_cycle_count) == 32'(TIMEOUT - 1));

    // Simultaneous completions are folded into a single add.
    always_comb begin
        w_add = '0;
        for (int k = 0; k < int'(CORES); k++) begin
            if (w_new[k]) begin
                w_add = w_add + SUM_W'(result_in[k*RESULT_W +: RESULT_W]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ready_q     <= '0;
            r_core_done   <= '0;
            r_result_lat  <= '0;
            r_total       <= '0;
            r_cycle_count <= '0;
            r_busy        <= 1'b0;
            r_all_done    <= 1'b0;
            r_timed_out   <= 1'b0;
            r_done_pulse  <= 1'b0;
`ifdef PER_CORE_CYCLES_EN
            r_core_cycles <= '0;
`endif
        end else begin
            r_ready_q    <= ready_in;
            r_done_pulse <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    if (start) begin
                        r_state       <= S_RUN;
                        r_core_done   <= '0;
                        r_result_lat  <= '0;
                        r_total       <= '0;
                        r_cycle_count <= '0;
                        r_busy        <= 1'b1;
                        r_all_done    <= 1'b0;
                        r_timed_out   <= 1'b0;
`ifdef PER_CORE_CYCLES_EN
                        r_core_cycles <= '0;
`endif
                    end
                end
                S_RUN: begin
                    r_core_done <= w_done_next;
                    r_total     <= r_total + w_add;
                    for (int k = 0; k < int'(CORES); k++) begin
                        if (w_new[k]) begin
                            r_result_lat[k*RESULT_W +: RESULT_W] <= result_in[k*RESULT_W +: RESULT_W];
`ifdef PER_CORE_CYCLES_EN
                            r_core_cycles[k*CYCLE_W +: CYCLE_W] <= r_cycle_count;
`endif
                        end
                    end
                    // Completion takes priority over a coincident timeout; the final cycle is not counted.
                    if (w_all) begin
                        r_state      <= S_DONE;
                        r_busy       <= 1'b0;
                        r_all_done   <= 1'b1;
                        r_done_pulse <= 1'b1;
                    end else if (w_to) begin
                        r_state      <= S_TIMEOUT;
                        r_busy       <= 1'b0;
                        r_timed_out  <= 1'b1;
                        r_done_pulse <= 1'b1;
                    end else if (r_cycle_count != '1) begin
                        r_cycle_count <= r_cycle_count + CYCLE_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign core_done   = r_core_done;
    assign result_lat  = r_result_lat;
    assign total       = r_total;
    assign cycle_count = r_cycle_count;
    assign busy        = r_busy;
    assign all_done    = r_all_done;
    assign timed_out   = r_timed_out;
    assign done_pulse  = r_done_pulse;
`ifdef PER_CORE_CYCLES_EN
    assign core_cycles = r_core_cycles;
`endif

endmodule

// File: tb/tb_multicore_done_aggregator.sv
// Randomized bench for multicore_done_aggregator against a per-run outcome model
// (fall schedule -> expected done set, total and cycle count). Honours PER_CORE_CYCLES_EN.
module tb_multicore_done_aggregator;

    localparam int NC = 4;
    localparam int RW = 8;
    localparam int CW = 16;
    localparam int SW = 16;
    localparam int TO = 100;

    logic              clk;
    logic              reset;
    logic              start;
    logic [NC-1:0]     ready_in;
    logic [NC*RW-1:0]  result_in;
    logic [NC-1:0]     core_done;
    logic [NC*RW-1:0]  result_lat;
    logic [SW-1:0]     total;
    logic [CW-1:0]     cycle_count;
    logic              busy;
    logic              all_done;
    logic              timed_out;
    logic              done_pulse;
`ifdef PER_CORE_CYCLES_EN
    logic [NC*CW-1:0]  core_cycles;
`endif

    multicore_done_aggregator #(
        .CORES(NC), .RESULT_W(RW), .CYCLE_W(CW), .SUM_W(SW), .TIMEOUT(TO)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .ready_in(ready_in),
        .result_in(result_in),
        .core_done(core_done),
        .result_lat(result_lat),
        .total(total),
        .cycle_count(cycle_count),
        .busy(busy),
        .all_done(all_done),
        .timed_out(timed_out),
        .done_pulse(done_pulse)
`ifdef PER_CORE_CYCLES_EN
        ,
        .core_cycles(core_cycles)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Scenario: first/second fall cycle per core (-1 = none) and the result driven at each.
    int sc_f1[NC];
    int sc_f2[NC];
    int sc_r1[NC];
    int sc_r2[NC];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_core_done"}, 64'(core_done), 64'(0));
        check({tag, "_lat"}, 64'(result_lat), 64'(0));
        check({tag, "_total"}, 64'(total), 64'(0));
        check({tag, "_cycles"}, 64'(cycle_count), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_all_done"}, 64'(all_done), 64'(0));
        check({tag, "_timed_out"}, 64'(timed_out), 64'(0));
        check({tag, "_pulse"}, 64'(done_pulse), 64'(0));
`ifdef PER_CORE_CYCLES_EN
        check({tag, "_core_cycles"}, 64'(core_cycles), 64'(0));
`endif
    endtask

    // Executes the current scenario; abort_at >= 0 asserts reset at that run cycle.
    task automatic run(input string name, input int abort_at);
        bit            exp_done;
        int            mx;
        int            last;
        logic [NC-1:0] exp_cd;
        int            exp_tot;
        int            exp_cnt;
        int            exp_lat[NC];
        int            pulses;
        bit            finished;

        // Outcome model: all first falls inside the window -> DONE at the latest one, else TIMEOUT.
        exp_done = 1'b1;
        mx = 0;
        for (int k = 0; k < NC; k++) begin
            if (sc_f1[k] < 0) exp_done = 1'b0;
            else if (sc_f1[k] > mx) mx = sc_f1[k];
        end
        if (mx > TO - 1) exp_done = 1'b0;
        last    = exp_done ? mx : TO - 1;
        exp_cnt = last;
        exp_tot = 0;
        for (int k = 0; k < NC; k++) begin
            exp_cd[k]  = (sc_f1[k] >= 0) && (sc_f1[k] <= last);
            exp_lat[k] = exp_cd[k] ? (sc_f1[k] & 255) : 0;
            exp_lat[k] = exp_cd[k] ? (sc_r1[k] & 255) : 0;
            exp_tot    = (exp_tot + exp_lat[k]) & 16'hFFFF;
        end

        @(negedge clk);
        ready_in  = '1;
        result_in = $urandom;
        start     = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        pulses   = 0;
        finished = 1'b0;
        for (int c = 0; c < 300 && !finished; c++) begin
            if (c > 0 && done_pulse) pulses++;
            if (c > 0 && !busy) begin
                finished = 1'b1;
            end else begin
                if (c == 0) check({name, "_busy_on_start"}, 64'(busy), 64'(1));
                if (c == abort_at) begin
                    logic [NC-1:0] part;
                    for (int k = 0; k < NC; k++) part[k] = (sc_f1[k] >= 0) && (sc_f1[k] < c);
                    check({name, "_partial_done"}, 64'(core_done), 64'(part));
                    reset = 1'b1;
                    #1;
                    check_all_zero({name, "_midreset"});
                    @(negedge clk);
                    reset    = 1'b0;
                    ready_in = '1;
                    return;
                end
                for (int k = 0; k < NC; k++) begin
                    if (sc_f1[k] == c) begin
                        ready_in[k] = 1'b0;
                        result_in[k*RW +: RW] = RW'(sc_r1[k]);
                    end else if (sc_f2[k] == c) begin
                        ready_in[k] = 1'b0;
                        result_in[k*RW +: RW] = RW'(sc_r2[k]);
                    end else begin
                        ready_in[k] = 1'b1;
                        result_in[k*RW +: RW] = RW'($urandom);
                    end
                end
                @(negedge clk);
            end
        end
        if (!finished) check({name, "_run_bound"}, 64'(0), 64'(1));

        check({name, "_all_done"}, 64'(all_done), 64'(exp_done));
        check({name, "_timed_out"}, 64'(timed_out), 64'(!exp_done));
        check({name, "_busy"}, 64'(busy), 64'(0));
        check({name, "_core_done"}, 64'(core_done), 64'(exp_cd));
        check({name, "_total"}, 64'(total), 64'(exp_tot));
        check({name, "_cycles"}, 64'(cycle_count), 64'(exp_cnt));
        for (int k = 0; k < NC; k++)
            check($sformatf("%s_lat%0d", name, k), 64'(result_lat[k*RW +: RW]), 64'(exp_lat[k]));
`ifdef PER_CORE_CYCLES_EN
        for (int k = 0; k < NC; k++)
            check($sformatf("%s_cc%0d", name, k), 64'(core_cycles[k*CW +: CW]),
                  64'(exp_cd[k] ? sc_f1[k] : 0));
`endif

        // Terminal state must hold through further strobe activity.
        for (int i = 0; i < 6; i++) begin
            ready_in  = NC'($urandom);
            result_in = $urandom;
            @(negedge clk);
            if (done_pulse) pulses++;
        end
        check({name, "_pulses"}, 64'(pulses), 64'(1));
        check({name, "_hold_core_done"}, 64'(core_done), 64'(exp_cd));
        check({name, "_hold_total"}, 64'(total), 64'(exp_tot));
        check({name, "_hold_cycles"}, 64'(cycle_count), 64'(exp_cnt));
        ready_in = '1;
        @(negedge clk);
    endtask

    task automatic clear_f2();
        for (int k = 0; k < NC; k++) begin
            sc_f2[k] = -1;
            sc_r2[k] = 0;
        end
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        ready_in  = '1;
        result_in = '0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        ready_in = 4'b0101;
        @(negedge clk);
        ready_in = '1;
        @(negedge clk);
        check("idle_ignores_fall", 64'(core_done), 64'(0));

        sc_f1 = '{10, 20, 30, 40}; sc_r1 = '{5, 7, 11, 13}; clear_f2();
        run("seq4", -1);

        sc_f1 = '{9, 5, 5, 12}; sc_r1 = '{9, 3, 4, 9}; clear_f2();
        run("simul", -1);

        sc_f1 = '{4, 6, 7, 8}; sc_r1 = '{8, 1, 2, 3}; clear_f2();
        sc_f2[0] = 10; sc_r2[0] = 200;
        run("repeat", -1);

        sc_f1 = '{5, 6, 7, -1}; sc_r1 = '{1, 1, 1, 0}; clear_f2();
        run("timeout", -1);

        sc_f1 = '{TO - 1, 3, 50, 20}; sc_r1 = '{77, 1, 2, 3}; clear_f2();
        run("done_at_limit", -1);

        sc_f1 = '{3, 5, 60, 70}; sc_r1 = '{1, 2, 3, 4}; clear_f2();
        run("midreset", 15);

        sc_f1 = '{10, 20, 30, 40}; sc_r1 = '{5, 7, 11, 13}; clear_f2();
        run("after_reset", -1);

        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < NC; k++) begin
                sc_f1[k] = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 105));
                sc_r1[k] = int'($urandom_range(0, 255));
                sc_f2[k] = (sc_f1[k] >= 0 && $urandom_range(0, 2) == 0) ?
                           sc_f1[k] + int'($urandom_range(2, 15)) : -1;
                sc_r2[k] = int'($urandom_range(0, 255));
            end
            run($sformatf("rnd%0d", i), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicore_done_aggregator.md
Name: multicore_done_aggregator

Overview:
Synthesizable completion monitor for an N-core jimmy cluster; replaces the ad-hoc done-flag/cycle-count/sum logic in multicore benches. Watches each core's output-ready strobe (out_strobe bit 2) for a falling edge. On that edge it latches the core's result, marks the core done and accumulates a cluster total. Counts clock cycles from start until every core is done or a timeout fires, and reports status to the bench or a host port.

Parameters:
CORES, 4, number of monitored cores (1..8)
RESULT_W, 8, width of each core's result port
CYCLE_W, 16, width of the cycle counter
SUM_W, 16, width of the accumulated total (must be >= RESULT_W + clog2(CORES))
TIMEOUT, 50000, cycle limit before timeout (0 disables timeout)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  one-cycle pulse; arms a run (IDLE/DONE/TIMEOUT -> RUN)
ready_in  in  CORES  per-core out_strobe[2]
result_in  in  CORES*RESULT_W  per-core out_port_2 values, core k at [k*RESULT_W +: RESULT_W]
core_done  out  CORES  sticky per-core done flags
result_lat  out  CORES*RESULT_W  result captured at each core's done event
total  out  SUM_W  sum of captured results
cycle_count  out  CYCLE_W  cycles spent in RUN
busy  out  1  high in RUN
all_done  out  1  high in DONE
timed_out  out  1  high in TIMEOUT
done_pulse  out  1  one-cycle pulse on entry to DONE or TIMEOUT

Behaviour:
- Reset: state=IDLE; every output 0; ready_q (registered copy of ready_in) = 0.
- ready_q <= ready_in every cycle, in all states. fall[k] = ready_q[k] & ~ready_in[k] (combinational, same cycle as the low sample).
- IDLE: ignores fall. start -> RUN. On that edge: clear core_done, result_lat, total, cycle_count.
- RUN:
  - cycle_count increments every cycle and saturates at all-ones.
  - For each k with fall[k] & ~core_done[k]: set core_done[k]; result_lat[k] <= result_in[k].
  - total <= total + sum of result_in[k] over all such k. Simultaneous falls in one cycle are summed in one add. Arithmetic is unsigned and wraps at SUM_W.
  - A repeat falling edge from a core already done is ignored.
  - Next-state core_done all ones -> DONE, with done_pulse on the same edge. The cycle on which the last core's fall is seen is not counted, so cycle_count = number of RUN cycles before that fall.
  - TIMEOUT != 0 and cycle_count == TIMEOUT-1 without all done -> TIMEOUT, done_pulse. Partial core_done and total are held.
  - If all-done and timeout hit on the same cycle, DONE wins.
  - start while in RUN is ignored.
- DONE / TIMEOUT: all outputs held. start re-arms (clears and enters RUN).
- Reset mid-run: asynchronous clear to IDLE. A pending fall is lost.
- Latency: fall on ready_in visible in core_done/total one clock later.

Optional Feature:
Macro PER_CORE_CYCLES_EN.
- Defined: adds output core_cycles, CORES*CYCLE_W. At each core's done event, core_cycles[k] <= current cycle_count. It is cleared on reset and on start, and held otherwise.
- Undefined: port and registers absent. All other behaviour is identical.

Test Plan:
1. Reset, start, CORES=4. Cores fall at cycles 10, 20, 30, 40 with results 5, 7, 11, 13 -> all_done=1, total=36, core_done=4'b1111, cycle_count=40, one done_pulse.
2. Cores 1 and 2 fall on the same cycle with 3 and 4; core 0 at 9 (result 9), core 3 at 12 (result 9) -> total=25, result_lat slots correct.
3. Core 0 falls twice with results 8 then 200 -> result_lat[0]=8, total counts 8 only.
4. TIMEOUT=100, core 3 never falls, others return 1 -> timed_out=1 at cycle_count=99, total=3, core_done=4'b0111, busy=0.
5. Assert reset at cycle 15 of a run after two cores are done -> all outputs 0, state IDLE. A later start runs cleanly to all_done.
6. PER_CORE_CYCLES_EN defined, scenario 1 stimulus -> core_cycles = {40, 30, 20, 10} (core 3..0). With the macro undefined, the build elaborates without the port.
